// File: rtl/lsu_ctrl.sv
// Load/store unit controller: aligns a single load or store onto a 32-bit word bus,
// extends load data, and reports misalignment and bus timeout as one-cycle pulses.
//
// state | meaning
// IDLE  | waiting for start; misaligned requests are rejected here
// REQ   | bus_req asserted, waiting for bus_ack (up to 256 cycles)
// RESP  | transfer complete, done pulses for one cycle
module lsu_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        is_store,
    input  logic [1:0]  size,
    input  logic        sign,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic [31:0] rdata,
    output logic        exc_adel,
    output logic        exc_ades,
    output logic        bus_err,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata
);

    typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

    state_t      state, state_nxt;
    logic        store_q;
    logic        sign_q;
    logic [1:0]  size_q;
    logic [1:0]  off_q;
    logic [3:0]  be_q;
    logic [7:0]  wait_cnt;
    logic        err_q;
    logic        adel_q;
    logic        ades_q;

    logic        accept;
    logic        aligned;
    logic        timeout;
    logic [3:0]  be_calc;
    logic [31:0] wdata_rep;
    logic [7:0]  lane8;
    logic [15:0] lane16;
    logic [31:0] load_ext;

    always_comb begin
        aligned   = 1'b0;
        be_calc   = 4'b0000;
        wdata_rep = wdata;
        case (size)
            2'b00: begin
                aligned   = 1'b1;
                be_calc   = 4'b0001 << addr[1:0];
                wdata_rep = {4{wdata[7:0]}};
            end
            2'b01: begin
                aligned   = ~addr[0];
                be_calc   = addr[1] ? 4'b1100 : 4'b0011;
                wdata_rep = {2{wdata[15:0]}};
            end
            2'b10: begin
                aligned   = (addr[1:0] == 2'b00);
                be_calc   = 4'b1111;
                wdata_rep = wdata;
            end
            default: begin
                aligned   = 1'b0;
                be_calc   = 4'b0000;
                wdata_rep = wdata;
            end
        endcase
    end

    // Lane selection uses the offset latched at accept, not the live address.
    always_comb begin
        lane8    = bus_rdata[{off_q, 3'b000} +: 8];
        lane16   = off_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];
        load_ext = bus_rdata;
        case (size_q)
            2'b00:   load_ext = {{24{sign_q & lane8[7]}}, lane8};
            2'b01:   load_ext = {{16{sign_q & lane16[15]}}, lane16};
            default: load_ext = bus_rdata;
        endcase
    end

    assign accept  = (state == IDLE) && start;
    assign timeout = (state == REQ) && !bus_ack && (wait_cnt == 8'hFF);

    always_comb begin
        state_nxt = state;
        busy      = (state != IDLE);
        bus_req   = (state == REQ);
        bus_we    = 1'b0;
        bus_be    = 4'b0000;
        done      = (state == RESP) || err_q;
        bus_err   = err_q;
        exc_adel  = adel_q;
        exc_ades  = ades_q;
        case (state)
            IDLE: begin
                if (start && aligned) state_nxt = REQ;
            end
            REQ: begin
                bus_we = store_q;
                bus_be = be_q;
                if (bus_ack)                    state_nxt = RESP;
                else if (wait_cnt == 8'hFF)     state_nxt = IDLE;
            end
            RESP: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            store_q   <= 1'b0;
            sign_q    <= 1'b0;
            size_q    <= 2'b00;
            off_q     <= 2'b00;
            be_q      <= 4'b0000;
            wait_cnt  <= 8'd0;
            err_q     <= 1'b0;
            adel_q    <= 1'b0;
            ades_q    <= 1'b0;
            rdata     <= 32'h0;
            bus_addr  <= 32'h0;
            bus_wdata <= 32'h0;
        end else begin
            state  <= state_nxt;
            err_q  <= timeout;
            adel_q <= accept && !aligned && !is_store;
            ades_q <= accept && !aligned && is_store;
            if (accept && aligned) begin
                store_q   <= is_store;
                sign_q    <= sign;
                size_q    <= size;
                off_q     <= addr[1:0];
                be_q      <= be_calc;
                bus_addr  <= {addr[31:2], 2'b00};
                bus_wdata <= wdata_rep;
                wait_cnt  <= 8'd0;
            end else if (state == REQ && !bus_ack) begin
                wait_cnt <= wait_cnt + 8'd1;
            end
            if (state == REQ && bus_ack && !store_q)
                rdata <= load_ext;
        end
    end

endmodule
